// File: rtl/conv_tap_accumulator_if.sv
// Tap stream, MAC datapath and result stream bundled for the convolution tap sequencer.
// slave = sequencer side, master = fetch/MAC/writer side.
interface conv_tap_accumulator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_pixel;
  logic [DATA_WIDTH-1:0] s_weight;

  logic [DATA_WIDTH-1:0] mac_in;
  logic [DATA_WIDTH-1:0] mac_k;
  logic [DATA_WIDTH-1:0] mac_r;
  logic [DATA_WIDTH-1:0] mac_out;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_pixel, s_weight,
    output s_ready,
    output mac_in, mac_k, mac_r,
    input  mac_out,
    output m_valid, m_data,
    input  m_ready
  );

  modport master (
    output s_valid, s_pixel, s_weight,
    input  s_ready,
    input  mac_in, mac_k, mac_r,
    output mac_out,
    input  m_valid, m_data,
    output m_ready
  );
endinterface

// File: rtl/conv_tap_accumulator.sv
// Convolution tap sequencer: streams TAPS pixel*weight taps through an external MAC and emits one pixel.
// Optional build macro CONV_ACC_RELU_EN clamps negative results to zero when the result is loaded.
//
// state  | meaning
// ST_ACC | accepting taps, partial sum held in acc_q
// ST_OUT | finished pixel presented on m_data, waiting for m_ready
module conv_tap_accumulator #(
  parameter  int DATA_WIDTH = 32,
  parameter  int TAPS       = 9,
  localparam int CNT_W      = $clog2(TAPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] bias_i,
  conv_tap_accumulator_if.slave bus,
  output logic [CNT_W-1:0]      tap_cnt_o
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] res_d;
  logic [CNT_W-1:0]      tap_cnt_q;
  logic                  m_valid_q;
  logic                  s_ready_q;
  logic                  accept;
  logic                  last_tap;

  assign accept   = bus.s_valid && s_ready_q;
  assign last_tap = (tap_cnt_q == LAST_TAP);

  // MAC operands are pure wiring; bias seeds the sum only on the first tap of a pixel.
  assign bus.mac_in = bus.s_pixel;
  assign bus.mac_k  = bus.s_weight;
  assign bus.mac_r  = (tap_cnt_q == '0) ? bias_i : acc_q;

`ifdef CONV_ACC_RELU_EN
  assign res_d = bus.mac_out[DATA_WIDTH-1] ? '0 : bus.mac_out;
`else
  assign res_d = bus.mac_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      res_q     <= '0;
      tap_cnt_q <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else if (abort_i) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      res_q     <= '0;
      tap_cnt_q <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_q <= bus.mac_out;
            if (last_tap) begin
              tap_cnt_q <= '0;
              res_q     <= res_d;
              state_q   <= ST_OUT;
              m_valid_q <= 1'b1;
              s_ready_q <= 1'b0;
            end else begin
              tap_cnt_q <= tap_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            state_q   <= ST_ACC;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_ACC;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = res_q;
  assign tap_cnt_o   = tap_cnt_q;

endmodule
